rr_arb_mux_4ch: RTL and testbench
=================================

Name: rr_arb_mux_4ch

Overview:
- Upstream feeder/controller for the 4-to-1 5-bit data mux stage.
- Arbitrates four valid/ready source channels with round-robin priority.
- Drives the mux select from its own grant and registers the selected word into a single-entry output stage with valid/ready toward the consumer.
- Sits between four producer channels and one shared downstream sink.

Parameters:
- WIDTH, 5, data width of each channel and of out_data.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in0  input  WIDTH  channel 0 data.
- in1  input  WIDTH  channel 1 data.
- in2  input  WIDTH  channel 2 data.
- in3  input  WIDTH  channel 3 data.
- in_valid  input  4  per-channel valid; bit i belongs to in{i}.
- in_ready  output  4  per-channel ready, one-hot or zero.
- select  output  2  current grant index (combinational); drives the mux select.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered selected word.
- out_chan  output  2  channel index that out_data came from.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
  - While rst_n=0: out_valid=0, out_data=0, out_chan=0, ptr=0.
  - in_ready=0 combinationally whenever out_valid=0 and in_valid=0.
- State: 2-bit ptr (highest-priority channel), output register {out_valid, out_data, out_chan}.
- load = !out_valid || out_ready. The stage can accept a word this cycle, including the same cycle the consumer drains it.
- Grant:
  - g = first i in order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with in_valid[i]=1.
  - select = g. When no channel is valid, select = ptr.
  - any_req = |in_valid.
- in_ready[g] = load && any_req. All other bits are 0, so at most one bit is ever set.
- Transfer in: when load && any_req, at the next edge:
  - out_data <= in{g}
  - out_chan <= g
  - out_valid <= 1
  - ptr <= g+1 mod 4 (wraps 3 -> 0)
- Drain only: when out_valid && out_ready && !any_req, out_valid <= 0. out_data and out_chan hold their values.
- Stall: when out_valid && !out_ready, all state holds, in_ready = 0, and select still reflects the arbitration result.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 word per cycle while out_ready=1.
- Fairness: a channel that holds in_valid=1 is granted within 4 transfers.
- ptr changes only on an input transfer, never on an idle or stall cycle.
- Source rule: sources must hold data and valid stable until their handshake completes. The block does not check this.
- Reset mid-operation: any held word is dropped and ptr returns to 0. No handshake completes in the cycle rst_n deasserts asynchronously.
- No combinational path from out_ready to out_valid or out_data. There is a combinational path from out_ready and in_valid to in_ready and select.

Decomposition:
- Package rr_arb_pkg:
  - localparam N_CH = 4
  - typedef logic [1:0] chan_idx_t
- Sub-module rr_pick4 (combinational):
  - Inputs: req[3:0], ptr.
  - Outputs: gnt_idx, any.
  - Implementation: rotate req by ptr, take the lowest set bit, rotate the index back.
- The top instantiates rr_pick4 plus an internal 4-to-1 data select.
  - Alternatively, instantiate the existing mux_4to1_5bit with select=g when WIDTH=5.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 with in_valid=4'b1111 and out_ready=1, then release.
  - Required: out_valid=0, out_data=0, out_chan=0 during reset; the first grant after release is channel 0 (select=0).
- Full contention rotation:
  - Stimulus: in_valid=4'b1111, out_ready=1, in0..3 = 5'd1, 5'd2, 5'd3, 5'd4.
  - Required: out_data sequence 1,2,3,4,1,... on consecutive cycles; out_chan 0,1,2,3,0; exactly one in_ready bit per cycle.
- Pointer skip and wrap:
  - Stimulus: after a grant to channel 2 (ptr=3), set in_valid=4'b0011.
  - Required: next grant is channel 0, then 1. Then with in_valid=4'b1000, grant 3 and ptr wraps to 0.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with out_valid=1, out_data=5'd17, in_valid=4'b0100.
  - Required: out_data stays 17, in_ready=0, ptr unchanged. When out_ready=1, the same-cycle reload gives out_data=in2 one cycle later.
- Idle drain:
  - Stimulus: out_valid=1 and out_ready=1 with in_valid=0.
  - Required: out_valid=0 next cycle; out_data unchanged; select equals ptr.
- Async reset mid-stream:
  - Stimulus: assert rst_n=0 between edges while out_valid=1 and out_data=5'd9.
  - Required: out_valid=0 immediately, before the next clk edge; ptr=0 after release.

Source files
------------

// File: rtl/rr_arb_mux_4ch_pkg.sv
// Shared types and constants for the four-channel round-robin feeder.
package rr_arb_pkg;
    localparam int N_CH = 4;
    typedef logic [1:0] chan_idx_t;
endpackage

// File: rtl/rr_arb_mux_4ch_pick4.sv
// Combinational round-robin picker: first requester at or after ptr.
module rr_pick4
    import rr_arb_pkg::*;
(
    input  logic [N_CH-1:0] req,
    input  chan_idx_t       ptr,
    output chan_idx_t       gnt_idx,
    output logic            any
);
    logic [N_CH-1:0] rot;
    chan_idx_t       off;

    always_comb begin
        // Bit j of rot is req[(ptr + j) mod 4], so the lowest set bit is the winner offset.
        rot = 4'({req, req} >> ptr);
        off = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = chan_idx_t'(i);
            end
        end
        gnt_idx = ptr + off;
        any     = |req;
    end
endmodule

// File: rtl/rr_arb_mux_4ch.sv
// Round-robin arbiter over four valid/ready sources feeding a single-entry
// registered output stage; the grant also drives the downstream mux select.
module rr_arb_mux_4ch
    import rr_arb_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [N_CH-1:0]  in_valid,
    output logic [N_CH-1:0]  in_ready,
    output logic [1:0]       select,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_chan,
    input  logic             out_ready
);
    chan_idx_t        ptr_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    chan_idx_t        out_chan_reg;

    chan_idx_t        gnt;
    logic             any_req;
    logic             load;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] in_arr [N_CH];

    assign in_arr[0] = in0;
    assign in_arr[1] = in1;
    assign in_arr[2] = in2;
    assign in_arr[3] = in3;

    rr_pick4 u_pick (
        .req     (in_valid),
        .ptr     (ptr_reg),
        .gnt_idx (gnt),
        .any     (any_req)
    );

    // The stage may refill in the same cycle the consumer drains it.
    assign load     = !out_valid_reg || out_ready;
    assign select   = gnt;
    assign sel_data = in_arr[gnt];

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ready
            assign in_ready[gi] = load && any_req && (gnt == chan_idx_t'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_chan_reg  <= '0;
        end else if (load && any_req) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= sel_data;
            out_chan_reg  <= gnt;
            ptr_reg       <= gnt + 2'd1;
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_chan  = out_chan_reg;
endmodule

// File: tb/tb_rr_arb_mux_4ch.sv
// Randomised and directed bench for rr_arb_mux_4ch against a behavioural model.
module tb_rr_arb_mux_4ch;
    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] in0, in1, in2, in3;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [1:0]   select;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   out_chan;
    logic         out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_arb_mux_4ch #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .select    (select),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Behavioural model: priority scan starting at ptr, single-entry output slot.
    int           m_ptr;
    bit           m_ov;
    int           m_od;
    int           m_oc;

    function automatic int winner(input int ptr, input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic int word_of(input int ch);
        case (ch)
            0: return int'(in0);
            1: return int'(in1);
            2: return int'(in2);
            default: return int'(in3);
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr = 0; m_ov = 0; m_od = 0; m_oc = 0;
        end else begin
            int g;
            g = winner(m_ptr, in_valid);
            if ((!m_ov || out_ready) && g >= 0) begin
                m_od  = word_of(g);
                m_oc  = g;
                m_ov  = 1;
                m_ptr = (g + 1) % 4;
            end else if (m_ov && out_ready) begin
                m_ov = 0;
            end
        end
    end

    always @(negedge clk) begin
        int g;
        logic [3:0] exp_rdy;
        g = winner(m_ptr, in_valid);
        exp_rdy = ((!m_ov || out_ready) && g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk("model_select", 32'(select), 32'((g >= 0) ? g : m_ptr));
        chk("model_in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("model_out_valid", 32'(out_valid), 32'(m_ov));
        chk("model_out_data", 32'(out_data), 32'(m_od));
        chk("model_out_chan", 32'(out_chan), 32'(m_oc));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b1; in_valid = 4'b1111;
        in0 = 5'd1; in1 = 5'd2; in2 = 5'd3; in3 = 5'd4;
        repeat (3) cyc();
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_out_data", 32'(out_data), 0);
        chk("reset_out_chan", 32'(out_chan), 0);
        rst_n = 1'b1;
        #1;
        chk("reset_first_select", 32'(select), 0);

        // Full contention: strict rotation 0,1,2,3,0,...
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("rot_data", 32'(out_data), 32'((k % 4) + 1));
            chk("rot_chan", 32'(out_chan), 32'(k % 4));
        end

        // Grant channel 2, then ptr=3 must skip to 0 then 1, then wrap via 3.
        in_valid = 4'b0100;
        cyc(); chk("skip_ch2", 32'(out_chan), 2);
        in_valid = 4'b0011;
        cyc(); chk("skip_ch0", 32'(out_chan), 0);
        cyc(); chk("skip_ch1", 32'(out_chan), 1);
        in_valid = 4'b1000;
        cyc(); chk("wrap_ch3", 32'(out_chan), 3);
        in_valid = 4'b0000;
        #1;
        chk("wrap_ptr0", 32'(select), 0);

        // Idle drain: slot empties, data holds, select shows ptr.
        cyc();
        chk("drain_valid", 32'(out_valid), 0);
        chk("drain_data", 32'(out_data), 4);
        chk("drain_select", 32'(select), 0);

        // Backpressure with a pending request on channel 2.
        in2 = 5'd17; in_valid = 4'b0100;
        cyc(); chk("bp_load", 32'(out_data), 17);
        in2 = 5'd22; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("bp_hold_data", 32'(out_data), 17);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_select", 32'(select), 2);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'(4'b0100));
        cyc(); chk("bp_reload", 32'(out_data), 22);

        // Async reset mid-stream while holding 9.
        in1 = 5'd9; in_valid = 4'b0010;
        cyc();
        in_valid = 4'b0000; out_ready = 1'b0;
        #1;
        chk("ar_hold", 32'(out_data), 9);
        chk("ar_ptr_before", 32'(select), 2);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_valid_now", 32'(out_valid), 0);
        chk("ar_data_now", 32'(out_data), 0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("ar_ptr_after", 32'(select), 0);

        // Randomised traffic checked each cycle by the model.
        for (int k = 0; k < 2000; k++) begin
            cyc();
            in0 = W'($urandom); in1 = W'($urandom);
            in2 = W'($urandom); in3 = W'($urandom);
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        cyc();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
